// File: rtl/usb3_pkg.sv
// Shared definitions for the FX3 slave-FIFO read path: state codes (READ is also
// decoded by the DA RAM cache), socket default and counter width.
package usb3_pkg;

  localparam int CNT_W = 12;

  localparam logic [1:0] RD_SOCKET_DEF = 2'd3;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_FLAG = 4'd1;
  localparam logic [3:0] ST_ADDR      = 4'd2;
  localparam logic [3:0] ST_OE        = 4'd3;
  localparam logic [3:0] ST_RD_LAT    = 4'd4;
  localparam logic [3:0] ST_RD_PRE    = 4'd5;
  localparam logic [3:0] ST_READ      = 4'd6;
  localparam logic [3:0] ST_END       = 4'd7;
  localparam logic [3:0] ST_GAP       = 4'd8;

  typedef enum logic [3:0] {
    RS_IDLE      = ST_IDLE,
    RS_WAIT_FLAG = ST_WAIT_FLAG,
    RS_ADDR      = ST_ADDR,
    RS_OE        = ST_OE,
    RS_RD_LAT    = ST_RD_LAT,
    RS_RD_PRE    = ST_RD_PRE,
    RS_READ      = ST_READ,
    RS_END       = ST_END,
    RS_GAP       = ST_GAP
  } rd_state_e;

  // Load value for a down-counter that must stay in a state for n cycles.
  function automatic logic [CNT_W-1:0] cnt_m1(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/usb3_burst_cnt.sv
// Load/decrement counter shared by the latency, word, gap, strobe and timeout counts.
module usb3_burst_cnt
  import usb3_pkg::*;
(
  input  logic             wrclock,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/usb3_slave_fifo_rd.sv
// FX3 slave-FIFO burst read controller feeding the DA RAM cache.
// Optional WAIT_FLAG timeout is built only when USB_RD_TIMEOUT_EN is defined.
module usb3_slave_fifo_rd
  import usb3_pkg::*;
#(
  parameter int         BURST_LEN  = 256,
  parameter int         RD_LATENCY = 3,
  parameter int         GAP_CYC    = 4,
  parameter logic [1:0] RD_SOCKET  = RD_SOCKET_DEF
`ifdef USB_RD_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 4096
`endif
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        usb3_flaga,
  input  logic [31:0] usb3_dq,
  output logic        usb3_slcs_n,
  output logic        usb3_sloe_n,
  output logic        usb3_slrd_n,
  output logic [1:0]  usb3_fifoaddr,
  output logic [31:0] data,
  output logic        data_valid,
  output logic [3:0]  usb_rd_state,
  output logic        burst_done,
  output logic        rd_timeout
);

  rd_state_e        state_q, state_d;
  logic             ph_load, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             st_load, st_zero;
  logic             strb_on_q, strb_on_d;
  logic             tmo_hit, tmo_fire;
  logic             in_cs_s, in_oe_s;

  logic        slcs_n_q, slcs_n_d, sloe_n_q, sloe_n_d, slrd_n_q, slrd_n_d;
  logic [1:0]  fifoaddr_q, fifoaddr_d;
  logic [31:0] data_q, data_d;
  logic        data_valid_q, data_valid_d, burst_done_q, burst_done_d;
  logic        rd_timeout_q, rd_timeout_d;

  // Phase counter: RD_LAT length, word count in READ, idle cycles in GAP.
  usb3_burst_cnt u_phase (
    .wrclock (wrclock),
    .rst_n   (rst_n),
    .load    (ph_load),
    .dec     (1'b1),
    .load_val(ph_val),
    .zero    (ph_zero)
  );

  // Strobe counter runs independently so SLRD spans exactly one burst even
  // when the read latency overlaps the word phase.
  assign st_load = (state_q == RS_OE) && (state_d == RS_RD_LAT);

  usb3_burst_cnt u_strobe (
    .wrclock (wrclock),
    .rst_n   (rst_n),
    .load    (st_load),
    .dec     (strb_on_q),
    .load_val(cnt_m1(BURST_LEN)),
    .zero    (st_zero)
  );

`ifdef USB_RD_TIMEOUT_EN
  logic tmo_zero;

  usb3_burst_cnt u_timeout (
    .wrclock (wrclock),
    .rst_n   (rst_n),
    .load    ((state_d == RS_WAIT_FLAG) && (state_q != RS_WAIT_FLAG)),
    .dec     (state_q == RS_WAIT_FLAG),
    .load_val(cnt_m1(TIMEOUT_CYC)),
    .zero    (tmo_zero)
  );

  assign tmo_hit = tmo_zero;
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state; enable=0 in WAIT_FLAG takes priority over a ready flag.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (enable) state_d = RS_WAIT_FLAG;
        else        state_d = RS_IDLE;
      end
      RS_WAIT_FLAG: begin
        if (!enable) begin
          state_d = RS_IDLE;
        end else if (usb3_flaga) begin
          state_d = RS_ADDR;
        end else if (tmo_hit) begin
          state_d  = RS_IDLE;
          tmo_fire = 1'b1;
        end else begin
          state_d = RS_WAIT_FLAG;
        end
      end
      RS_ADDR:   state_d = RS_OE;
      RS_OE:     state_d = RS_RD_LAT;
      RS_RD_LAT: begin
        if (ph_zero) state_d = RS_RD_PRE;
        else         state_d = RS_RD_LAT;
      end
      RS_RD_PRE: state_d = RS_READ;
      RS_READ: begin
        if (ph_zero) state_d = RS_END;
        else         state_d = RS_READ;
      end
      RS_END:    state_d = RS_GAP;
      RS_GAP: begin
        if (ph_zero) state_d = RS_WAIT_FLAG;
        else         state_d = RS_GAP;
      end
      default:   state_d = RS_IDLE;
    endcase
  end

  // Phase counter is reloaded on entry to each timed state.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = {CNT_W{1'b0}};
    if (state_d != state_q) begin
      case (state_d)
        RS_RD_LAT: begin ph_load = 1'b1; ph_val = cnt_m1(RD_LATENCY - 1); end
        RS_READ:   begin ph_load = 1'b1; ph_val = cnt_m1(BURST_LEN);      end
        RS_GAP:    begin ph_load = 1'b1; ph_val = cnt_m1(GAP_CYC);        end
        default:   begin ph_load = 1'b0; ph_val = {CNT_W{1'b0}};          end
      endcase
    end else begin
      ph_load = 1'b0;
      ph_val  = {CNT_W{1'b0}};
    end
  end

  // Strobe window opens on entry to RD_LAT and closes after BURST_LEN cycles.
  always_comb begin
    strb_on_d = strb_on_q;
    if (st_load) begin
      strb_on_d = 1'b1;
    end else if (strb_on_q && st_zero) begin
      strb_on_d = 1'b0;
    end else begin
      strb_on_d = strb_on_q;
    end
  end

  // Outputs decoded from the next state so they are valid in the state's own cycle.
  always_comb begin
    in_cs_s      = (state_d >= RS_ADDR) && (state_d <= RS_READ);
    in_oe_s      = (state_d >= RS_OE) && (state_d <= RS_READ);
    slcs_n_d     = !in_cs_s;
    sloe_n_d     = !in_oe_s;
    slrd_n_d     = !strb_on_d;
    fifoaddr_d   = in_cs_s ? RD_SOCKET : 2'd0;
    data_d       = usb3_dq;
    data_valid_d = (state_d == RS_READ);
    burst_done_d = (state_d == RS_END);
    rd_timeout_d = tmo_fire;
  end

  // FSM and registered outputs.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RS_IDLE;
      strb_on_q    <= 1'b0;
      slcs_n_q     <= 1'b1;
      sloe_n_q     <= 1'b1;
      slrd_n_q     <= 1'b1;
      fifoaddr_q   <= 2'd0;
      data_q       <= 32'd0;
      data_valid_q <= 1'b0;
      burst_done_q <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      strb_on_q    <= strb_on_d;
      slcs_n_q     <= slcs_n_d;
      sloe_n_q     <= sloe_n_d;
      slrd_n_q     <= slrd_n_d;
      fifoaddr_q   <= fifoaddr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      burst_done_q <= burst_done_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign usb3_slcs_n   = slcs_n_q;
  assign usb3_sloe_n   = sloe_n_q;
  assign usb3_slrd_n   = slrd_n_q;
  assign usb3_fifoaddr = fifoaddr_q;
  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign usb_rd_state  = state_q;
  assign burst_done    = burst_done_q;
  assign rd_timeout    = rd_timeout_q;

endmodule
